// File: rtl/centroid_tracker.sv
// Per-frame foreground centroid and bounding-box extractor.
// Accumulates thresholded pixel coordinates over a frame, then divides sums by count serially.
module centroid_tracker #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int MIN_PIXELS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] threshold,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic       vde,
  input  logic [2:0] pixel_in,
  output logic [9:0] centroid_x,
  output logic [9:0] centroid_y,
  output logic       centroid_valid,
  output logic [9:0] bbox_min_x,
  output logic [9:0] bbox_min_y,
  output logic [9:0] bbox_max_x,
  output logic [9:0] bbox_max_y,
  output logic       update,
  output logic       busy
);

  typedef enum logic [1:0] {ACC_IDLE, WAIT_SOF, ACCUM} acc_state_t;
  typedef enum logic [1:0] {DIV_IDLE, DIVIDE, PUBLISH} div_state_t;

  localparam logic [9:0]  LAST_X    = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0]  LAST_Y    = 10'(FRAME_HEIGHT - 1);
  localparam logic [18:0] MIN_COUNT = 19'(MIN_PIXELS);
  localparam logic [4:0]  LAST_STEP = 5'd27;

  // One restoring-division step: returns {remainder, shifted quotient}.
  function automatic logic [46:0] div_step(input logic [18:0] rem,
                                           input logic [27:0] quo,
                                           input logic [18:0] dvs);
    logic [19:0] trial;
    logic [18:0] rem_n;
    logic        bit_n;
    trial = {rem, quo[27]};
    if (trial >= {1'b0, dvs}) begin
      rem_n = 19'(trial - {1'b0, dvs});
      bit_n = 1'b1;
    end else begin
      rem_n = trial[18:0];
      bit_n = 1'b0;
    end
    return {rem_n, quo[26:0], bit_n};
  endfunction

  acc_state_t  acc_state, acc_next;
  div_state_t  div_state, div_next;

  logic [27:0] sum_x, sum_y, sum_x_nx, sum_y_nx;
  logic [18:0] count, count_nx;
  logic [9:0]  min_x, min_y, max_x, max_y;
  logic [9:0]  min_x_nx, min_y_nx, max_x_nx, max_y_nx;

  logic [18:0] dvs, rem_x, rem_y;
  logic [27:0] quo_x, quo_y;
  logic [4:0]  step_cnt;
  logic [9:0]  op_min_x, op_min_y, op_max_x, op_max_y;
  logic        pub_ok;

  logic sof, frame_end, fg, acc_en, capture, div_load;

  assign sof       = vde && (draw_x == 10'd0) && (draw_y == 10'd0);
  assign frame_end = vde && (draw_x == LAST_X) && (draw_y == LAST_Y);
  assign fg        = vde && (pixel_in >= threshold);
  // The SOF pixel itself belongs to the frame, so WAIT_SOF accumulates on that cycle.
  assign acc_en    = enable && ((acc_state == ACCUM) || ((acc_state == WAIT_SOF) && sof));
  assign capture   = acc_en && frame_end;
  assign div_load  = capture && (div_state == DIV_IDLE);
  assign busy      = (div_state != DIV_IDLE);

  always_comb begin
    sum_x_nx = sum_x;
    sum_y_nx = sum_y;
    count_nx = count;
    min_x_nx = min_x;
    min_y_nx = min_y;
    max_x_nx = max_x;
    max_y_nx = max_y;
    if (fg) begin
      sum_x_nx = sum_x + 28'(draw_x);
      sum_y_nx = sum_y + 28'(draw_y);
      count_nx = count + 19'd1;
      min_x_nx = (draw_x < min_x) ? draw_x : min_x;
      min_y_nx = (draw_y < min_y) ? draw_y : min_y;
      max_x_nx = (draw_x > max_x) ? draw_x : max_x;
      max_y_nx = (draw_y > max_y) ? draw_y : max_y;
    end
  end

  always_comb begin
    acc_next = acc_state;
    if (!enable) begin
      acc_next = ACC_IDLE;
    end else begin
      case (acc_state)
        ACC_IDLE: acc_next = WAIT_SOF;
        WAIT_SOF: if (sof) acc_next = ACCUM;
        ACCUM:    acc_next = ACCUM;
        default:  acc_next = ACC_IDLE;
      endcase
    end
  end

  always_comb begin
    div_next = div_state;
    if (!enable) begin
      div_next = DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: if (capture) div_next = (count_nx >= MIN_COUNT) ? DIVIDE : PUBLISH;
        DIVIDE:   if (step_cnt == LAST_STEP) div_next = PUBLISH;
        PUBLISH:  div_next = DIV_IDLE;
        default:  div_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_state <= ACC_IDLE;
      div_state <= DIV_IDLE;
    end else begin
      acc_state <= acc_next;
      div_state <= div_next;
    end
  end

  // Accumulators clear at frame end so the next frame overlaps the running division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
      min_x <= 10'h3FF;
      min_y <= 10'h3FF;
      max_x <= '0;
      max_y <= '0;
    end else if (!enable || capture) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
      min_x <= 10'h3FF;
      min_y <= 10'h3FF;
      max_x <= '0;
      max_y <= '0;
    end else if (acc_en) begin
      sum_x <= sum_x_nx;
      sum_y <= sum_y_nx;
      count <= count_nx;
      min_x <= min_x_nx;
      min_y <= min_y_nx;
      max_x <= max_x_nx;
      max_y <= max_y_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs            <= '0;
      rem_x          <= '0;
      rem_y          <= '0;
      quo_x          <= '0;
      quo_y          <= '0;
      step_cnt       <= '0;
      op_min_x       <= '0;
      op_min_y       <= '0;
      op_max_x       <= '0;
      op_max_y       <= '0;
      pub_ok         <= 1'b0;
      centroid_x     <= '0;
      centroid_y     <= '0;
      centroid_valid <= 1'b0;
      bbox_min_x     <= '0;
      bbox_min_y     <= '0;
      bbox_max_x     <= '0;
      bbox_max_y     <= '0;
      update         <= 1'b0;
    end else begin
      update <= 1'b0;
      if (div_load) begin
        dvs      <= count_nx;
        quo_x    <= sum_x_nx;
        quo_y    <= sum_y_nx;
        rem_x    <= '0;
        rem_y    <= '0;
        step_cnt <= '0;
        op_min_x <= min_x_nx;
        op_min_y <= min_y_nx;
        op_max_x <= max_x_nx;
        op_max_y <= max_y_nx;
        pub_ok   <= (count_nx >= MIN_COUNT);
      end else if (div_state == DIVIDE) begin
        {rem_x, quo_x} <= div_step(rem_x, quo_x, dvs);
        {rem_y, quo_y} <= div_step(rem_y, quo_y, dvs);
        step_cnt       <= step_cnt + 5'd1;
      end
      // A low-count frame still pulses update but keeps the previous centroid and box.
      if (!enable) begin
        centroid_valid <= 1'b0;
      end else if (div_state == PUBLISH) begin
        update         <= 1'b1;
        centroid_valid <= pub_ok;
        if (pub_ok) begin
          centroid_x <= quo_x[9:0];
          centroid_y <= quo_y[9:0];
          bbox_min_x <= op_min_x;
          bbox_min_y <= op_min_y;
          bbox_max_x <= op_max_x;
          bbox_max_y <= op_max_y;
        end
      end
    end
  end

endmodule
